program_sequencer: RTL and testbench

- Consumer end of the instruction decoder's control interface.
- Holds the program counter that addresses instruction ROM.
- Acts on the decoder's jmp, cal_f, ret_f and rst_f outputs, and keeps a hardware return-address stack for CAL/RET.
- Sits between the decoder outputs and the ROM address input. It closes the fetch loop.

---
 rtl/program_sequencer.sv | 137 +++++++++++++
 tb/tb_program_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/program_sequencer.sv
// program_sequencer: program counter plus hardware return-address stack; pc updates one cycle after decode, en=0 freezes all state.
// Optional SEQ_STACK_GUARD_EN: suppresses over/underflowing calls/returns and raises sticky stk_ovf/stk_unf.
module program_sequencer #(
  parameter int CNTR_WIDTH  = 8,
  parameter int STACK_DEPTH = 8,
  localparam int SP_WIDTH   = $clog2(STACK_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  rst_f,
  input  logic                  jmp,
  input  logic                  cal_f,
  input  logic                  ret_f,
  input  logic [CNTR_WIDTH-1:0] jmp_addr,
  output logic [CNTR_WIDTH-1:0] pc,
  output logic [SP_WIDTH-1:0]   stack_cnt,
  output logic                  stack_empty,
  output logic                  stack_full,
  output logic                  stk_ovf,
  output logic                  stk_unf
);

  localparam int PTR_WIDTH = $clog2(STACK_DEPTH);

  logic [CNTR_WIDTH-1:0] stack_mem [STACK_DEPTH];
  logic [PTR_WIDTH-1:0]  wr_ptr;
  logic [PTR_WIDTH-1:0]  rd_ptr;
  logic [PTR_WIDTH-1:0]  wr_ptr_nxt;
  logic [CNTR_WIDTH-1:0] pc_nxt;
  logic [CNTR_WIDTH-1:0] pc_inc;
  logic [SP_WIDTH-1:0]   cnt_nxt;
  logic                  push;
  logic                  clr_flags;
  logic                  set_ovf;
  logic                  set_unf;

  assign pc_inc      = pc + CNTR_WIDTH'(1);
  assign rd_ptr      = wr_ptr - PTR_WIDTH'(1);
  assign stack_empty = (stack_cnt == '0);
  assign stack_full  = (stack_cnt == SP_WIDTH'(STACK_DEPTH));

  always_comb begin
    pc_nxt     = pc;
    cnt_nxt    = stack_cnt;
    wr_ptr_nxt = wr_ptr;
    push       = 1'b0;
    clr_flags  = 1'b0;
    set_ovf    = 1'b0;
    set_unf    = 1'b0;
    if (!rst_f) begin
      pc_nxt     = '0;
      cnt_nxt    = '0;
      wr_ptr_nxt = '0;
      clr_flags  = 1'b1;
    end else if (jmp && cal_f) begin
      if (!stack_full) begin
        push       = 1'b1;
        wr_ptr_nxt = wr_ptr + PTR_WIDTH'(1);
        cnt_nxt    = stack_cnt + SP_WIDTH'(1);
        pc_nxt     = jmp_addr;
      end else begin
`ifdef SEQ_STACK_GUARD_EN
        pc_nxt  = pc_inc;
        set_ovf = 1'b1;
`else
        // Ring overwrites the oldest entry; count stays saturated.
        push       = 1'b1;
        wr_ptr_nxt = wr_ptr + PTR_WIDTH'(1);
        pc_nxt     = jmp_addr;
`endif
      end
    end else if (jmp && ret_f) begin
      if (!stack_empty) begin
        wr_ptr_nxt = rd_ptr;
        cnt_nxt    = stack_cnt - SP_WIDTH'(1);
        pc_nxt     = stack_mem[rd_ptr];
      end else begin
`ifdef SEQ_STACK_GUARD_EN
        pc_nxt  = pc_inc;
        set_unf = 1'b1;
`else
        // Empty pop still walks the ring and returns whatever is stored there.
        wr_ptr_nxt = rd_ptr;
        pc_nxt     = stack_mem[rd_ptr];
`endif
      end
    end else if (jmp) begin
      pc_nxt = jmp_addr;
    end else begin
      pc_nxt = pc_inc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc        <= '0;
      stack_cnt <= '0;
      wr_ptr    <= '0;
    end else if (en) begin
      pc        <= pc_nxt;
      stack_cnt <= cnt_nxt;
      wr_ptr    <= wr_ptr_nxt;
    end
  end

  // Return-address storage carries no reset so it can map onto a register file.
  always_ff @(posedge clk) begin
    if (en && push) begin
      stack_mem[wr_ptr] <= pc_inc;
    end
  end

`ifdef SEQ_STACK_GUARD_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stk_ovf <= 1'b0;
      stk_unf <= 1'b0;
    end else if (en) begin
      if (clr_flags) begin
        stk_ovf <= 1'b0;
        stk_unf <= 1'b0;
      end else begin
        stk_ovf <= stk_ovf | set_ovf;
        stk_unf <= stk_unf | set_unf;
      end
    end
  end
`else
  assign stk_ovf = 1'b0;
  assign stk_unf = 1'b0;

  logic unused_flags;
  assign unused_flags = clr_flags | set_ovf | set_unf;
`endif

endmodule

// File: tb/tb_program_sequencer.sv
// Directed + random bench for program_sequencer (CNTR_WIDTH=8, STACK_DEPTH=4) against a ring-buffer reference model.
module tb_program_sequencer;

  localparam int DEPTH = 4;
`ifdef SEQ_STACK_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       en;
  logic       rst_f;
  logic       jmp;
  logic       cal_f;
  logic       ret_f;
  logic [7:0] jmp_addr;
  logic [7:0] pc;
  logic [2:0] stack_cnt;
  logic       stack_empty;
  logic       stack_full;
  logic       stk_ovf;
  logic       stk_unf;

  int n_cmp = 0;
  int n_bad = 0;

  int m_pc, m_cnt, m_ptr;
  bit m_ovf, m_unf;
  int m_mem [DEPTH];
  bit m_wr  [DEPTH];

  program_sequencer #(.CNTR_WIDTH(8), .STACK_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .en(en), .rst_f(rst_f), .jmp(jmp), .cal_f(cal_f),
    .ret_f(ret_f), .jmp_addr(jmp_addr), .pc(pc), .stack_cnt(stack_cnt),
    .stack_empty(stack_empty), .stack_full(stack_full), .stk_ovf(stk_ovf), .stk_unf(stk_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"},    32'(pc),          m_pc);
    check({tag, ".cnt"},   32'(stack_cnt),   m_cnt);
    check({tag, ".empty"}, 32'(stack_empty), int'(m_cnt == 0));
    check({tag, ".full"},  32'(stack_full),  int'(m_cnt == DEPTH));
    check({tag, ".ovf"},   32'(stk_ovf),     int'(m_ovf));
    check({tag, ".unf"},   32'(stk_unf),     int'(m_unf));
  endtask

  task automatic model_reset();
    m_pc = 0; m_cnt = 0; m_ptr = 0; m_ovf = 0; m_unf = 0;
  endtask

  // Stack modelled as a ring of DEPTH return addresses with a write index.
  task automatic model_upd(input bit e, input bit rf, input bit j, input bit c, input bit r, input int a);
    if (!e) return;
    if (!rf) begin
      model_reset();
    end else if (j && c) begin
      if (m_cnt < DEPTH || !GUARD) begin
        m_mem[m_ptr] = (m_pc + 1) % 256;
        m_wr[m_ptr]  = 1'b1;
        m_ptr        = (m_ptr + 1) % DEPTH;
        if (m_cnt < DEPTH) m_cnt++;
        m_pc = a;
      end else begin
        m_pc  = (m_pc + 1) % 256;
        m_ovf = 1'b1;
      end
    end else if (j && r) begin
      if (m_cnt > 0 || !GUARD) begin
        m_ptr = (m_ptr + DEPTH - 1) % DEPTH;
        m_pc  = m_mem[m_ptr];
        if (m_cnt > 0) m_cnt--;
      end else begin
        m_pc  = (m_pc + 1) % 256;
        m_unf = 1'b1;
      end
    end else if (j) begin
      m_pc = a;
    end else begin
      m_pc = (m_pc + 1) % 256;
    end
  endtask

  task automatic step(input string tag, input bit e, input bit rf, input bit j, input bit c,
                      input bit r, input logic [7:0] a);
    @(negedge clk);
    en = e; rst_f = rf; jmp = j; cal_f = c; ret_f = r; jmp_addr = a;
    @(posedge clk);
    model_upd(e, rf, j, c, r, int'(a));
    #1;
    check_all(tag);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step("idle", 1, 1, 0, 0, 0, 8'h00);
  endtask

  task automatic call(input logic [7:0] a);
    step("call", 1, 1, 1, 1, 0, a);
  endtask

  task automatic ret();
    step("ret", 1, 1, 1, 0, 1, 8'h00);
  endtask

  task automatic soft_rst();
    step("soft_rst", 1, 0, 0, 0, 0, 8'h00);
  endtask

  initial begin
    bit e, rf, j, c, r;
    logic [7:0] a;
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i] = 0;
      m_wr[i]  = 1'b0;
    end
    rst = 1'b1; en = 1'b0; rst_f = 1'b1; jmp = 1'b0; cal_f = 1'b0; ret_f = 1'b0; jmp_addr = 8'h00;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    idle(5);
    check("seq_pc5", 32'(pc), 32'h05);
    step("hold", 0, 1, 1, 1, 0, 8'h33);
    step("hold", 0, 0, 1, 0, 0, 8'h44);
    check("hold_pc5", 32'(pc), 32'h05);

    step("jump", 1, 1, 1, 0, 0, 8'hFE);
    idle(2);
    check("wrap_pc0", 32'(pc), 32'h00);

    idle(3);
    call(8'h20);
    check("nest_call1", 32'(pc), 32'h20);
    idle(1);
    call(8'h40);
    check("nest_cnt2", 32'(stack_cnt), 32'd2);
    ret();
    check("nest_ret1", 32'(pc), 32'h22);
    ret();
    check("nest_ret2", 32'(pc), 32'h04);
    check("nest_empty", 32'(stack_empty), 32'd1);

    step("qual_nojmp", 1, 1, 0, 1, 1, 8'h77);
    step("cal_and_ret", 1, 1, 1, 1, 1, 8'h30);
    check("both_is_call", 32'(pc), 32'h30);
    ret();

    step("jump", 1, 1, 1, 0, 0, 8'hFF);
    call(8'h10);
    ret();
    check("push_wrap0", 32'(pc), 32'h00);

    soft_rst();
    call(8'h10); call(8'h11); call(8'h12); call(8'h13);
    check("ovf_full", 32'(stack_full), 32'd1);
    step("jump", 1, 1, 1, 0, 0, 8'h50);
    call(8'h60);
`ifdef SEQ_STACK_GUARD_EN
    check("ovf_pc", 32'(pc), 32'h51);
    check("ovf_flag", 32'(stk_ovf), 32'd1);
`else
    check("ovf_pc", 32'(pc), 32'h60);
`endif
    check("ovf_cnt", 32'(stack_cnt), 32'd4);
    soft_rst();
    check("clr_cnt", 32'(stack_cnt), 32'd0);

    idle(7);
    ret();
`ifdef SEQ_STACK_GUARD_EN
    check("unf_pc", 32'(pc), 32'h08);
    check("unf_flag", 32'(stk_unf), 32'd1);
`endif
    call(8'h90);
    check("unf_call_pc", 32'(pc), 32'h90);

    soft_rst();
    call(8'h20);
    call(8'h30);
    #2;
    rst = 1'b1; en = 1'b1; rst_f = 1'b1; jmp = 1'b0; cal_f = 1'b0; ret_f = 1'b0;
    #1;
    model_reset();
    check("arst_pc", 32'(pc), 32'h00);
    check("arst_cnt", 32'(stack_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    model_upd(1, 1, 0, 0, 0, 0);
    #1;
    check_all("arst_resume");
    check("arst_pc1", 32'(pc), 32'h01);

    for (int n = 0; n < 400; n++) begin
      e  = ($urandom_range(0, 9) != 0);
      rf = ($urandom_range(0, 24) != 0);
      j  = ($urandom_range(0, 1) == 1);
      c  = ($urandom_range(0, 3) == 0);
      r  = ($urandom_range(0, 2) == 0);
      a  = 8'($urandom);
      // Never pop a ring slot that was never written (its contents are undefined).
      if (!GUARD && j && r && !c && m_cnt == 0 && !m_wr[(m_ptr + DEPTH - 1) % DEPTH]) j = 1'b0;
      step("rand", e, rf, j, c, r, a);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
